// File: rtl/line_cache_if.sv
// Bundles the requester-side fetch port and the SDRAM line-fill port of line_cache.
interface line_cache_if #(
  parameter int AW = 23,
  parameter int DW = 16
);
  logic          cache_req;
  logic [AW-1:0] cache_addr;
  logic          cache_valid;
  logic [DW-1:0] cache_data;
  logic          rom_req;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          rom_valid;

  // slave is the cache itself; master is the requester/SDRAM side driving it
  modport slave (
    input  cache_req, cache_addr, rom_data, rom_valid,
    output cache_valid, cache_data, rom_req, rom_addr
  );

  modport master (
    output cache_req, cache_addr, rom_data, rom_valid,
    input  cache_valid, cache_data, rom_req, rom_addr
  );
endinterface

// File: rtl/line_cache.sv
// Direct-mapped read-only line cache with early restart, flush and hit/miss counters,
// sitting between a ROM fetch port and the shared SDRAM controller.
module line_cache #(
  parameter int AW    = 23,
  parameter int DW    = 16,
  parameter int IDX_W = 8,
  parameter int OFS_W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  line_cache_if.slave  bus,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);
  localparam int TW    = AW - IDX_W - OFS_W;
  localparam int LINES = 1 << IDX_W;
  localparam int WORDS = 1 << (IDX_W + OFS_W);

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, DONE} state_t;

  state_t state, state_next;

  logic [TW-1:0]    tag_mem  [LINES];
  logic [DW-1:0]    data_mem [WORDS];
  logic [TW-1:0]    tag_dout;
  logic [DW-1:0]    data_dout;
  logic [LINES-1:0] valid_bits;

  logic [AW-1:0]    req_addr;
  logic [OFS_W-1:0] fill_ofs;
  logic             flush_seen;

  logic [TW-1:0]    req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFS_W-1:0] req_ofs;
  logic [IDX_W-1:0] cache_idx;
  logic [OFS_W-1:0] cache_ofs;

  logic accept, hit, miss, fill_word, last_word;

  assign req_tag   = req_addr[AW-1:IDX_W+OFS_W];
  assign req_idx   = req_addr[IDX_W+OFS_W-1:OFS_W];
  assign req_ofs   = req_addr[OFS_W-1:0];
  assign cache_idx = bus.cache_addr[IDX_W+OFS_W-1:OFS_W];
  assign cache_ofs = bus.cache_addr[OFS_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    hit        = 1'b0;
    miss       = 1'b0;
    fill_word  = 1'b0;
    last_word  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cache_req) begin
          accept     = 1'b1;
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (valid_bits[req_idx] && (tag_dout == req_tag)) begin
          hit        = 1'b1;
          state_next = IDLE;
        end else begin
          miss       = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        if (bus.rom_valid) begin
          fill_word = 1'b1;
          if (fill_ofs == '1) begin
            last_word  = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reads happen only while IDLE and writes only during FILL, so the RAM ports never collide
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_dout  <= tag_mem[cache_idx];
      data_dout <= data_mem[{cache_idx, cache_ofs}];
    end
    if (fill_word) data_mem[{req_idx, fill_ofs}] <= bus.rom_data;
    if (last_word) tag_mem[req_idx] <= req_tag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.cache_valid <= 1'b0;
      bus.cache_data  <= '0;
      bus.rom_req     <= 1'b0;
      bus.rom_addr    <= '0;
      hit_count       <= '0;
      miss_count      <= '0;
      valid_bits      <= '0;
      req_addr        <= '0;
      fill_ofs        <= '0;
      flush_seen      <= 1'b0;
    end else begin
      bus.cache_valid <= 1'b0;
      if (accept) req_addr <= bus.cache_addr;
      if (hit) begin
        bus.cache_valid <= 1'b1;
        bus.cache_data  <= data_dout;
        hit_count       <= hit_count + 16'd1;
      end
      if (miss) begin
        bus.rom_req  <= 1'b1;
        bus.rom_addr <= {req_tag, req_idx, {OFS_W{1'b0}}};
        fill_ofs     <= '0;
        flush_seen   <= 1'b0;
        miss_count   <= miss_count + 16'd1;
      end
      if (fill_word) begin
        bus.rom_addr <= bus.rom_addr + AW'(1);
        fill_ofs     <= fill_ofs + OFS_W'(1);
        if (fill_ofs == req_ofs) begin
          bus.cache_valid <= 1'b1;
          bus.cache_data  <= bus.rom_data;
        end
      end
      if (last_word) begin
        bus.rom_req <= 1'b0;
        if (!flush_seen && !flush) valid_bits[req_idx] <= 1'b1;
      end
      // A flush mid-fill lets the burst finish but keeps the line from becoming valid
      if (flush) begin
        valid_bits <= '0;
        if (state == FILL) flush_seen <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_line_cache.sv
// Scenario-driven bench for line_cache: the bench plays both requester and SDRAM,
// queueing the expected read word at request time and popping it when cache_valid is due.
module tb_line_cache;
  localparam int AW    = 23;
  localparam int DW    = 16;
  localparam int IDX_W = 8;
  localparam int OFS_W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  line_cache_if #(.AW(AW), .DW(DW)) bus ();

  line_cache #(.AW(AW), .DW(DW), .IDX_W(IDX_W), .OFS_W(OFS_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_hits   = 16'd0;
  logic [15:0] exp_misses = 16'd0;
  logic [DW-1:0] exp_q [$];

  // SDRAM contents: depends on every address bit so that aliasing tags return different words
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return a[15:0] ^ {a[22:16], 9'h0} ^ 16'hC3A5;
  endfunction

  task automatic run_access(input logic [AW-1:0] addr, input bit exp_miss, input int gap,
                            input int flush_at, input string name);
    logic [AW-1:0]    base;
    logic [OFS_W-1:0] ofs;
    logic [DW-1:0]    exp_d;
    base = {addr[AW-1:OFS_W], {OFS_W{1'b0}}};
    ofs  = addr[OFS_W-1:0];
    exp_q.push_back(rom_word(addr));
    @(negedge clk);
    bus.cache_req  = 1'b1;
    bus.cache_addr = addr;
    @(negedge clk);
    bus.cache_req  = 1'b0;
    bus.cache_addr = ~addr;
    @(negedge clk);
    if (!exp_miss) begin
      exp_hits = exp_hits + 16'd1;
      exp_d = exp_q.pop_front();
      n_checks++; if (bus.cache_valid !== 1'b1) $display("[TB] FAIL %s hit_valid: got %b want 1", name, bus.cache_valid); else n_pass++;
      n_checks++; if (bus.cache_data !== exp_d) $display("[TB] FAIL %s hit_data: got %h want %h", name, bus.cache_data, exp_d); else n_pass++;
      n_checks++; if (bus.rom_req !== 1'b0) $display("[TB] FAIL %s hit_rom_req: got %b want 0", name, bus.rom_req); else n_pass++;
    end else begin
      exp_misses = exp_misses + 16'd1;
      n_checks++; if (bus.cache_valid !== 1'b0) $display("[TB] FAIL %s miss_valid: got %b want 0", name, bus.cache_valid); else n_pass++;
      for (int k = 0; k < (1 << OFS_W); k++) begin
        repeat (gap) @(negedge clk);
        n_checks++; if (bus.rom_req !== 1'b1) $display("[TB] FAIL %s rom_req[%0d]: got %b want 1", name, k, bus.rom_req); else n_pass++;
        n_checks++; if (bus.rom_addr !== base + AW'(k)) $display("[TB] FAIL %s rom_addr[%0d]: got %h want %h", name, k, bus.rom_addr, base + AW'(k)); else n_pass++;
        bus.rom_valid = 1'b1;
        bus.rom_data  = rom_word(base + AW'(k));
        if (k == flush_at) flush = 1'b1;
        @(negedge clk);
        bus.rom_valid = 1'b0;
        bus.rom_data  = '0;
        flush         = 1'b0;
        if (k == int'(ofs)) begin
          exp_d = exp_q.pop_front();
          n_checks++; if (bus.cache_valid !== 1'b1) $display("[TB] FAIL %s restart_valid: got %b want 1", name, bus.cache_valid); else n_pass++;
          n_checks++; if (bus.cache_data !== exp_d) $display("[TB] FAIL %s restart_data: got %h want %h", name, bus.cache_data, exp_d); else n_pass++;
        end else begin
          n_checks++; if (bus.cache_valid !== 1'b0) $display("[TB] FAIL %s stray_valid[%0d]: got %b want 0", name, k, bus.cache_valid); else n_pass++;
        end
      end
      n_checks++; if (bus.rom_req !== 1'b0) $display("[TB] FAIL %s rom_req_end: got %b want 0", name, bus.rom_req); else n_pass++;
    end
    n_checks++; if (hit_count !== exp_hits) $display("[TB] FAIL %s hit_count: got %0d want %0d", name, hit_count, exp_hits); else n_pass++;
    n_checks++; if (miss_count !== exp_misses) $display("[TB] FAIL %s miss_count: got %0d want %0d", name, miss_count, exp_misses); else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++; if (bus.cache_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", bus.cache_valid); else n_pass++;
    n_checks++; if (bus.cache_data !== '0) $display("[TB] FAIL reset_data: got %h want 0", bus.cache_data); else n_pass++;
    n_checks++; if (bus.rom_req !== 1'b0) $display("[TB] FAIL reset_rom_req: got %b want 0", bus.rom_req); else n_pass++;
    n_checks++; if (bus.rom_addr !== '0) $display("[TB] FAIL reset_rom_addr: got %h want 0", bus.rom_addr); else n_pass++;
    n_checks++; if (hit_count !== 16'd0) $display("[TB] FAIL reset_hits: got %0d want 0", hit_count); else n_pass++;
    n_checks++; if (miss_count !== 16'd0) $display("[TB] FAIL reset_misses: got %0d want 0", miss_count); else n_pass++;
  endtask

  task automatic test_cold_miss();
    run_access(23'h000104, 1'b1, 0, -1, "cold_miss");
  endtask

  task automatic test_early_restart();
    run_access(23'h000206, 1'b1, 3, -1, "early_restart");
  endtask

  task automatic test_hit();
    run_access(23'h000207, 1'b0, 0, -1, "hit");
  endtask

  task automatic test_back_to_back();
    run_access(23'h000204, 1'b0, 0, -1, "b2b_hit_a");
    run_access(23'h000104, 1'b0, 0, -1, "b2b_hit_b");
    run_access(23'h000205, 1'b0, 0, -1, "b2b_hit_c");
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    run_access(23'h000206, 1'b1, 0, -1, "flush_refetch");
  endtask

  task automatic test_flush_during_fill();
    run_access(23'h000500, 1'b1, 1, 1, "flush_mid_fill");
    run_access(23'h000501, 1'b1, 0, -1, "after_mid_flush");
    run_access(23'h000503, 1'b0, 0, -1, "refilled_hit");
    run_access(23'h000600, 1'b1, 0, 3, "flush_last_word");
    run_access(23'h000602, 1'b1, 2, -1, "after_last_flush");
  endtask

  task automatic test_conflict();
    logic [15:0] start_misses;
    start_misses = miss_count;
    run_access(23'h000104, 1'b1, 0, -1, "conflict_a");
    run_access(23'h040104, 1'b1, 0, -1, "conflict_b");
    run_access(23'h000104, 1'b1, 0, -1, "conflict_c");
    n_checks++; if (miss_count - start_misses !== 16'd3) $display("[TB] FAIL conflict_delta: got %0d want 3", miss_count - start_misses); else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk);
    bus.cache_req  = 1'b1;
    bus.cache_addr = 23'h000303;
    @(negedge clk);
    bus.cache_req  = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bus.rom_valid = 1'b1;
      bus.rom_data  = rom_word(23'h000300 + AW'(k));
      @(negedge clk);
    end
    bus.rom_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hits   = 16'd0;
    exp_misses = 16'd0;
    exp_q.delete();
    n_checks++; if (bus.rom_req !== 1'b0) $display("[TB] FAIL rstfill_rom_req: got %b want 0", bus.rom_req); else n_pass++;
    n_checks++; if (bus.cache_valid !== 1'b0) $display("[TB] FAIL rstfill_valid: got %b want 0", bus.cache_valid); else n_pass++;
    n_checks++; if (hit_count !== 16'd0) $display("[TB] FAIL rstfill_hits: got %0d want 0", hit_count); else n_pass++;
    n_checks++; if (miss_count !== 16'd0) $display("[TB] FAIL rstfill_misses: got %0d want 0", miss_count); else n_pass++;
    run_access(23'h000303, 1'b1, 0, -1, "after_reset");
    run_access(23'h000301, 1'b0, 0, -1, "after_reset_hit");
  endtask

  initial begin
    reset          = 1'b1;
    flush          = 1'b0;
    bus.cache_req  = 1'b0;
    bus.cache_addr = '0;
    bus.rom_valid  = 1'b0;
    bus.rom_data   = '0;
    test_reset();
    test_cold_miss();
    test_early_restart();
    test_hit();
    test_back_to_back();
    test_flush();
    test_flush_during_fill();
    test_conflict();
    test_reset_mid_fill();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
